// File: rtl/pscb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pscb_pkg
// Brief    : Shared FSM encoding and stage lane wiring for the pscb network
// Revision : 1.0 - initial release
// ============================================================================
package pscb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Destination lane of source lane i in the inter-stage wiring of stage s.
    // The last stage is a perfect shuffle; earlier stages exchange odd/even
    // lanes across SPLIT-sized blocks.
    function automatic int perm_dest(input int n, input int s, input int i);
        int stages;
        int split;
        stages = $clog2(n);
        if (s < stages - 1) begin
            split = 1 << (s + 1);
            if ((((i / split) % 2) == 0) && ((i % 2) == 1)) begin
                return i + split - 1;
            end else if ((((i / split) % 2) == 1) && ((i % 2) == 0)) begin
                return i - split + 1;
            end else begin
                return i;
            end
        end else begin
            split = 1 << (stages - 1);
            if (i < split) begin
                return 2 * i;
            end else begin
                return 2 * (i - split) + 1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pscb_route_stage.sv
`default_nettype none
// ============================================================================
// Module   : pscb_route_stage
// Brief    : One runtime-selected network stage: lane wiring plus 2x2 swap nodes
// Revision : 1.0 - initial release
// ============================================================================
module pscb_route_stage
    import pscb_pkg::*;
#(
    parameter  int INPUTS = 32,
    parameter  int W      = 8,
    localparam int NODES  = INPUTS / 2,
    localparam int STAGES = $clog2(INPUTS),
    localparam int CW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic [CW-1:0]       i_stage,
    input  logic [NODES-1:0]    i_scb,
    input  logic [INPUTS*W-1:0] i_data,
    output logic [INPUTS*W-1:0] o_data
);

    logic [STAGES-1:0][INPUTS-1:0][W-1:0] w_perm;
    logic [INPUTS-1:0][W-1:0]             w_sel;

    // Every stage's wiring is static; the stage index only picks among them.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        for (genvar i = 0; i < INPUTS; i++) begin : g_lane
            localparam int c_dest = perm_dest(INPUTS, s, i);
            assign w_perm[s][c_dest] = i_data[i*W +: W];
        end
    end

    always_comb begin
        w_sel = w_perm[0];
        for (int s = 1; s < STAGES; s++) begin
            if (i_stage == CW'(s)) begin
                w_sel = w_perm[s];
            end
        end
    end

    for (genvar k = 0; k < NODES; k++) begin : g_node
        assign o_data[(2*k)*W   +: W] = i_scb[k] ? w_sel[2*k+1] : w_sel[2*k];
        assign o_data[(2*k+1)*W +: W] = i_scb[k] ? w_sel[2*k]   : w_sel[2*k+1];
    end

endmodule
`default_nettype wire

// File: rtl/pscb_route_iter.sv
`default_nettype none
// ============================================================================
// Module   : pscb_route_iter
// Brief    : Iterative payload router applying pscb control words one stage/cycle
// Revision : 1.0 - initial release
// ============================================================================
module pscb_route_iter
    import pscb_pkg::*;
#(
    parameter  int INPUTS = 32,
    parameter  int W      = 8,
    localparam int NODES  = INPUTS / 2,
    localparam int STAGES = $clog2(INPUTS),
    localparam int CW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [STAGES*NODES-1:0] i_scb,
    input  logic [INPUTS*W-1:0]     i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [INPUTS*W-1:0]     o_data,
    output logic                    o_busy
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CW-1:0]           r_cnt;
    logic [INPUTS*W-1:0]     r_data;
    logic [STAGES*NODES-1:0] r_scb;
    logic [INPUTS*W-1:0]     w_stage_out;
    logic                    w_last;

    assign w_last = (r_cnt == CW'(STAGES - 1));

    pscb_route_stage #(
        .INPUTS (INPUTS),
        .W      (W)
    ) u_stage (
        .i_stage (r_cnt),
        .i_scb   (r_scb[r_cnt*NODES +: NODES]),
        .i_data  (r_data),
        .o_data  (w_stage_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Data and control are only captured at acceptance, so inputs may change freely while busy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_scb  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_data <= i_data;
                        r_scb  <= i_scb;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_data <= w_stage_out;
                    if (!w_last) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data = r_data;
    assign o_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
